// File: rtl/ui_overlay_engine.sv
// Table-driven UI overlay: N_SLOTS programmable widget rectangles mapped onto the sprite atlas.
// Two-stage pipeline from VGA counters to atlas address, object flag, winning slot and highlight.
module ui_overlay_engine #(
  parameter int unsigned N_SLOTS      = 16,
  parameter int unsigned IDX_W        = $clog2(N_SLOTS),
  parameter int unsigned ATLAS_W      = 360,
  parameter int unsigned ATLAS_H      = 240,
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned SCALE_SHIFT  = 1,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              frame_tick,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic              cfg_en,
  input  logic [1:0]        cfg_mode,
  input  logic [8:0]        cfg_x,
  input  logic [8:0]        cfg_y,
  input  logic [8:0]        cfg_w,
  input  logic [8:0]        cfg_h,
  input  logic [8:0]        cfg_u,
  input  logic [8:0]        cfg_v,
  output logic              cfg_err,
  input  logic [8:0]        bar_len,
  input  logic [IDX_W-1:0]  sel_idx,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              isObject,
  output logic [IDX_W-1:0]  obj_idx,
  output logic              highlight
);

  localparam int unsigned CW   = 10;
  localparam int unsigned UW   = 9;
  localparam int unsigned BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_BAR    = 2'd2;
  localparam logic [1:0] MODE_SELECT = 2'd3;

  // Slot table
  logic          r_en   [N_SLOTS];
  logic [1:0]    r_mode [N_SLOTS];
  logic [UW-1:0] r_x0   [N_SLOTS];
  logic [UW-1:0] r_y0   [N_SLOTS];
  logic [UW-1:0] r_w    [N_SLOTS];
  logic [UW-1:0] r_h    [N_SLOTS];
  logic [UW-1:0] r_u    [N_SLOTS];
  logic [UW-1:0] r_v    [N_SLOTS];
  logic          r_cfg_err;

  logic [BC_W-1:0] r_blink_cnt;
  logic            r_blink_phase;

  // Stage 1
  logic [CW-1:0]      w_x;
  logic [CW-1:0]      w_y;
  logic [CW-1:0]      w_dx   [N_SLOTS];
  logic [CW-1:0]      w_dy   [N_SLOTS];
  logic               w_in   [N_SLOTS];
  logic               w_gate [N_SLOTS];
  logic [N_SLOTS-1:0] w_hit;
  logic [UW-1:0]      w_au   [N_SLOTS];
  logic [UW-1:0]      w_av   [N_SLOTS];
  logic               w_cfg_ok;

  logic               r_s1_valid;
  logic [N_SLOTS-1:0] r_s1_hit;
  logic [UW-1:0]      r_s1_au [N_SLOTS];
  logic [UW-1:0]      r_s1_av [N_SLOTS];
  logic [IDX_W-1:0]   r_s1_sel;

  // Stage 2
  logic              w_found;
  logic [IDX_W-1:0]  w_win;
  logic [ADDR_W-1:0] w_addr;

  logic [ADDR_W-1:0] r_pixel_addr;
  logic              r_is_object;
  logic [IDX_W-1:0]  r_obj_idx;
  logic              r_highlight;

  // A widget must have non-zero size and lie fully inside the atlas
  always_comb begin : cfg_check
    w_cfg_ok = (cfg_w != '0) && (cfg_h != '0)
            && ((CW'(cfg_u) + CW'(cfg_w)) <= CW'(ATLAS_W))
            && ((CW'(cfg_v) + CW'(cfg_h)) <= CW'(ATLAS_H));
  end

  always_ff @(posedge clk) begin : cfg_regs
    if (rst) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        r_en[i]   <= 1'b0;
        r_mode[i] <= MODE_STATIC;
        r_x0[i]   <= '0;
        r_y0[i]   <= '0;
        r_w[i]    <= '0;
        r_h[i]    <= '0;
        r_u[i]    <= '0;
        r_v[i]    <= '0;
      end
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we & ~w_cfg_ok;
      if (cfg_we && w_cfg_ok) begin
        r_en[cfg_idx]   <= cfg_en;
        r_mode[cfg_idx] <= cfg_mode;
        r_x0[cfg_idx]   <= cfg_x;
        r_y0[cfg_idx]   <= cfg_y;
        r_w[cfg_idx]    <= cfg_w;
        r_h[cfg_idx]    <= cfg_h;
        r_u[cfg_idx]    <= cfg_u;
        r_v[cfg_idx]    <= cfg_v;
      end
    end
  end

  // Blink phase toggles every BLINK_FRAMES frame ticks; visible out of reset
  always_ff @(posedge clk) begin : blink_regs
    if (rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (frame_tick) begin
      if (r_blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BC_W'(1);
      end
    end
  end

  assign w_x = h_cnt >> SCALE_SHIFT;
  assign w_y = v_cnt >> SCALE_SHIFT;

  // Per-slot rectangle test, mode gate and atlas coordinates
  always_comb begin : s1_hit
    w_hit = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      w_dx[i] = w_x - CW'(r_x0[i]);
      w_dy[i] = w_y - CW'(r_y0[i]);
      w_in[i] = r_en[i]
             && (w_x >= CW'(r_x0[i])) && (w_x < (CW'(r_x0[i]) + CW'(r_w[i])))
             && (w_y >= CW'(r_y0[i])) && (w_y < (CW'(r_y0[i]) + CW'(r_h[i])));
      // dx < w already holds inside the rectangle, so dx < bar_len gives min(bar_len, w)
      case (r_mode[i])
        MODE_BLINK:  w_gate[i] = r_blink_phase;
        MODE_BAR:    w_gate[i] = (w_dx[i] < CW'(bar_len));
        MODE_SELECT: w_gate[i] = (IDX_W'(i) == sel_idx);
        default:     w_gate[i] = 1'b1;
      endcase
      w_hit[i] = w_in[i] & w_gate[i];
      w_au[i]  = UW'(CW'(r_u[i]) + w_dx[i]);
      w_av[i]  = UW'(CW'(r_v[i]) + w_dy[i]);
    end
  end

  // Atlas coordinates are captured here so a later config write cannot disturb this pixel
  always_ff @(posedge clk) begin : s1_regs
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_hit   <= '0;
      r_s1_sel   <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        r_s1_au[i] <= '0;
        r_s1_av[i] <= '0;
      end
    end else begin
      r_s1_valid <= 1'b1;
      r_s1_hit   <= w_hit;
      r_s1_sel   <= sel_idx;
      for (int i = 0; i < N_SLOTS; i++) begin
        r_s1_au[i] <= w_au[i];
        r_s1_av[i] <= w_av[i];
      end
    end
  end

  // Lowest-index hit wins
  always_comb begin : s2_pick
    w_found = 1'b0;
    w_win   = '0;
    for (int i = int'(N_SLOTS) - 1; i >= 0; i--) begin
      if (r_s1_hit[i]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(i);
      end
    end
    w_addr = ADDR_W'(r_s1_av[w_win]) * ADDR_W'(ATLAS_W) + ADDR_W'(r_s1_au[w_win]);
  end

  always_ff @(posedge clk) begin : s2_regs
    if (rst) begin
      r_is_object  <= 1'b0;
      r_pixel_addr <= '0;
      r_obj_idx    <= '0;
      r_highlight  <= 1'b0;
    end else if (r_s1_valid && w_found) begin
      r_is_object  <= 1'b1;
      r_pixel_addr <= w_addr;
      r_obj_idx    <= w_win;
      r_highlight  <= (w_win == r_s1_sel);
    end else begin
      r_is_object  <= 1'b0;
      r_pixel_addr <= '0;
      r_obj_idx    <= '0;
      r_highlight  <= 1'b0;
    end
  end

  assign cfg_err    = r_cfg_err;
  assign pixel_addr = r_pixel_addr;
  assign isObject   = r_is_object;
  assign obj_idx    = r_obj_idx;
  assign highlight  = r_highlight;

endmodule

// File: tb/tb_ui_overlay_engine.sv
// Bench for ui_overlay_engine: hand-computed vector table, directed corner sequences,
// and random traffic checked every cycle against a rectangle-list reference model.
module tb_ui_overlay_engine;

  localparam int unsigned N_SLOTS = 16;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned ADDR_W  = 17;
  localparam int unsigned BF      = 2;
  localparam int AW = 360;
  localparam int AH = 240;

  logic              clk = 1'b0;
  logic              rst;
  logic [9:0]        h_cnt, v_cnt;
  logic              frame_tick;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic              cfg_en;
  logic [1:0]        cfg_mode;
  logic [8:0]        cfg_x, cfg_y, cfg_w, cfg_h, cfg_u, cfg_v;
  logic              cfg_err;
  logic [8:0]        bar_len;
  logic [IDX_W-1:0]  sel_idx;
  logic [ADDR_W-1:0] pixel_addr;
  logic              isObject;
  logic [IDX_W-1:0]  obj_idx;
  logic              highlight;

  ui_overlay_engine #(.N_SLOTS(N_SLOTS), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .frame_tick(frame_tick),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_mode(cfg_mode),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_u(cfg_u), .cfg_v(cfg_v),
    .cfg_err(cfg_err), .bar_len(bar_len), .sel_idx(sel_idx), .pixel_addr(pixel_addr),
    .isObject(isObject), .obj_idx(obj_idx), .highlight(highlight)
  );

  always #5 clk = ~clk;

  typedef struct { bit en; int mode; int x; int y; int w; int h; int u; int v; } slot_t;
  typedef struct { bit obj; int addr; int idx; bit hl; } px_t;
  typedef struct { int h; int v; int bl; int sel; bit obj; int addr; int idx; bit hl; } vec_t;

  slot_t m_slot [N_SLOTS];
  int    m_ticks;
  px_t   exp1, exp_out;
  bit    exp_err;
  int    n_vec, n_err;
  vec_t  tbl [9];

  // Reference: scan the widget list in index order, first visible rectangle wins
  function automatic px_t model_pixel(int hc, int vc, int bl, int sel);
    px_t r;
    int x, y;
    bit vis;
    r.obj = 0; r.addr = 0; r.idx = 0; r.hl = 0;
    x = hc / 2;
    y = vc / 2;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (!m_slot[i].en) continue;
      if (x < m_slot[i].x || x >= m_slot[i].x + m_slot[i].w) continue;
      if (y < m_slot[i].y || y >= m_slot[i].y + m_slot[i].h) continue;
      case (m_slot[i].mode)
        0:       vis = 1;
        1:       vis = ((m_ticks / BF) % 2) == 0;
        2:       vis = (x - m_slot[i].x) < ((bl < m_slot[i].w) ? bl : m_slot[i].w);
        default: vis = (i == sel);
      endcase
      if (vis) begin
        r.obj  = 1;
        r.idx  = i;
        r.addr = (m_slot[i].v + y - m_slot[i].y) * AW + (m_slot[i].u + x - m_slot[i].x);
        r.hl   = (i == sel);
        return r;
      end
    end
    return r;
  endfunction

  // One clock: model the edge, then compare all outputs against the model
  task automatic cycle();
    px_t e;
    bit  ok;
    e  = model_pixel(int'(h_cnt), int'(v_cnt), int'(bar_len), int'(sel_idx));
    ok = (cfg_w != 0) && (cfg_h != 0) && (int'(cfg_u) + int'(cfg_w) <= AW)
      && (int'(cfg_v) + int'(cfg_h) <= AH);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N_SLOTS; i++) m_slot[i].en = 0;
      m_ticks = 0;
      exp_out = '{0, 0, 0, 0};
      exp1    = '{0, 0, 0, 0};
      exp_err = 0;
    end else begin
      if (cfg_we && ok) begin
        m_slot[cfg_idx].en   = cfg_en;
        m_slot[cfg_idx].mode = int'(cfg_mode);
        m_slot[cfg_idx].x    = int'(cfg_x);
        m_slot[cfg_idx].y    = int'(cfg_y);
        m_slot[cfg_idx].w    = int'(cfg_w);
        m_slot[cfg_idx].h    = int'(cfg_h);
        m_slot[cfg_idx].u    = int'(cfg_u);
        m_slot[cfg_idx].v    = int'(cfg_v);
      end
      if (frame_tick) m_ticks++;
      exp_out = exp1;
      exp1    = e;
      exp_err = cfg_we && !ok;
    end
    #1;
    n_vec++;
    if (isObject !== exp_out.obj || pixel_addr !== ADDR_W'(exp_out.addr) ||
        obj_idx !== IDX_W'(exp_out.idx) || highlight !== exp_out.hl || cfg_err !== exp_err) begin
      n_err++;
      $display("FAIL model @%0t: got obj=%b addr=%0d idx=%0d hl=%b err=%b, want obj=%b addr=%0d idx=%0d hl=%b err=%b",
               $time, isObject, pixel_addr, obj_idx, highlight, cfg_err,
               exp_out.obj, exp_out.addr, exp_out.idx, exp_out.hl, exp_err);
    end
  endtask

  task automatic expect_px(string name, bit obj, int addr, int idx, bit hl);
    n_vec++;
    if (isObject !== obj || pixel_addr !== ADDR_W'(addr) || obj_idx !== IDX_W'(idx) || highlight !== hl) begin
      n_err++;
      $display("FAIL %s: got obj=%b addr=%0d idx=%0d hl=%b, want obj=%b addr=%0d idx=%0d hl=%b",
               name, isObject, pixel_addr, obj_idx, highlight, obj, addr, idx, hl);
    end
  endtask

  task automatic expect_err(string name, bit want);
    n_vec++;
    if (cfg_err !== want) begin
      n_err++;
      $display("FAIL %s: got cfg_err=%b, want %b", name, cfg_err, want);
    end
  endtask

  task automatic write_slot(int idx, bit en, int mode, int x, int y, int w, int h, int u, int v);
    cfg_we = 1; cfg_idx = IDX_W'(idx); cfg_en = en; cfg_mode = 2'(mode);
    cfg_x = 9'(x); cfg_y = 9'(y); cfg_w = 9'(w); cfg_h = 9'(h); cfg_u = 9'(u); cfg_v = 9'(v);
    cycle();
    cfg_we = 0;
  endtask

  // Hold a pixel for two clocks so it reaches the outputs
  task automatic probe(int h, int v, int bl, int sel);
    h_cnt = 10'(h); v_cnt = 10'(v); bar_len = 9'(bl); sel_idx = IDX_W'(sel);
    cycle();
    cycle();
  endtask

  task automatic tick();
    frame_tick = 1;
    cycle();
    frame_tick = 0;
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0; m_ticks = 0;
    exp1 = '{0, 0, 0, 0}; exp_out = '{0, 0, 0, 0}; exp_err = 0;
    for (int i = 0; i < N_SLOTS; i++) m_slot[i] = '{0, 0, 0, 0, 0, 0, 0, 0};
    rst = 1; h_cnt = 0; v_cnt = 0; frame_tick = 0; cfg_we = 0; cfg_idx = 0; cfg_en = 0;
    cfg_mode = 0; cfg_x = 0; cfg_y = 0; cfg_w = 0; cfg_h = 0; cfg_u = 0; cfg_v = 0;
    bar_len = 10; sel_idx = 7;

    tbl[0] = '{160,  40, 10, 7, 1, 43200, 0, 0};
    tbl[1] = '{158,  40, 10, 7, 0,     0, 0, 0};
    tbl[2] = '{ 18, 430, 10, 7, 1, 70489, 2, 0};
    tbl[3] = '{ 20, 430, 10, 7, 0,     0, 0, 0};
    tbl[4] = '{ 18, 430,  0, 7, 0,     0, 0, 0};
    tbl[5] = '{478, 198, 10, 7, 1, 71799, 0, 0};
    tbl[6] = '{480, 198, 10, 7, 0,     0, 0, 0};
    tbl[7] = '{160,  40, 10, 0, 1, 43200, 0, 1};
    tbl[8] = '{ 19, 431, 60, 7, 1, 70489, 2, 0};

    cycle();
    cycle();
    expect_px("reset_out", 0, 0, 0, 0);
    expect_err("reset_err", 0);
    rst = 0;

    // Blink: visible out of reset, hidden after BF ticks, visible again after 2*BF
    write_slot(6, 1, 1, 0, 0, 4, 4, 10, 10);
    probe(2, 2, 10, 7);
    expect_px("blink_reset", 1, 3971, 6, 0);
    tick();
    probe(2, 2, 10, 7);
    expect_px("blink_1tick", 1, 3971, 6, 0);
    tick();
    probe(2, 2, 10, 7);
    expect_px("blink_off", 0, 0, 0, 0);
    tick();
    tick();
    probe(2, 2, 10, 7);
    expect_px("blink_on", 1, 3971, 6, 0);
    write_slot(6, 0, 1, 0, 0, 4, 4, 10, 10);

    // Vector table
    write_slot(0, 1, 0, 80, 20, 160, 80, 0, 120);
    write_slot(3, 1, 0, 80, 20, 160, 80, 40, 120);
    write_slot(2, 1, 2, 0, 215, 55, 20, 280, 195);
    for (int i = 0; i < 9; i++) begin
      probe(tbl[i].h, tbl[i].v, tbl[i].bl, tbl[i].sel);
      expect_px($sformatf("vec%0d", i), tbl[i].obj, tbl[i].addr, tbl[i].idx, tbl[i].hl);
    end

    write_slot(0, 0, 0, 80, 20, 160, 80, 0, 120);
    probe(160, 40, 10, 7);
    expect_px("slot3_after_disable", 1, 43240, 3, 0);

    // Select-only slot
    write_slot(4, 1, 3, 300, 200, 10, 10, 0, 0);
    probe(600, 400, 10, 4);
    expect_px("select_match", 1, 0, 4, 1);
    probe(600, 400, 10, 5);
    expect_px("select_other", 0, 0, 0, 0);

    // Rejected writes leave the slot intact and pulse cfg_err once
    write_slot(5, 1, 0, 0, 100, 5, 5, 0, 0);
    expect_err("err_good_write", 0);
    write_slot(5, 1, 0, 0, 100, 80, 5, 300, 0);
    expect_err("err_pulse_uw", 1);
    cycle();
    expect_err("err_clear_uw", 0);
    probe(8, 200, 10, 7);
    expect_px("slot5_kept_uw", 1, 4, 5, 0);
    write_slot(5, 1, 0, 0, 100, 0, 5, 100, 0);
    expect_err("err_pulse_w0", 1);
    cycle();
    expect_err("err_clear_w0", 0);
    probe(8, 200, 10, 7);
    expect_px("slot5_kept_w0", 1, 4, 5, 0);

    // Reset with a hit in flight
    h_cnt = 160; v_cnt = 40; sel_idx = 7;
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    expect_px("rst_out", 0, 0, 0, 0);
    cycle();
    expect_px("rst_drop", 0, 0, 0, 0);
    cycle();
    expect_px("rst_slots_off", 0, 0, 0, 0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int s;
      cfg_we = ($urandom_range(0, 9) == 0);
      cfg_idx = IDX_W'($urandom_range(0, 7));
      cfg_en = ($urandom_range(0, 3) != 0);
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_x = 9'($urandom_range(0, 300));
      cfg_y = 9'($urandom_range(0, 220));
      cfg_w = 9'(($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 100));
      cfg_h = 9'(($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 60));
      cfg_u = 9'($urandom_range(0, 359));
      cfg_v = 9'($urandom_range(0, 239));
      frame_tick = ($urandom_range(0, 19) == 0);
      bar_len = 9'($urandom_range(0, 60));
      sel_idx = IDX_W'($urandom_range(0, 7));
      rst = ($urandom_range(0, 499) == 0);
      s = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1 && m_slot[s].en) begin
        h_cnt = 10'(2 * (m_slot[s].x + $urandom_range(0, m_slot[s].w)) + $urandom_range(0, 1));
        v_cnt = 10'(2 * (m_slot[s].y + $urandom_range(0, m_slot[s].h)) + $urandom_range(0, 1));
      end else begin
        h_cnt = 10'($urandom_range(0, 1023));
        v_cnt = 10'($urandom_range(0, 1023));
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
